// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
//   Shared definitions for the FIFO read-side stream adapter:
//   - occ_t      : occupancy state of the two-entry output buffer
//   - OCC_MAX    : buffer capacity in words
//   - PKT_LEN_DEFAULT : default beats per packet for m_last generation
//   - occ_count(): occupancy state -> number of buffered words
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    localparam int OCC_MAX         = 2;
    localparam int PKT_LEN_DEFAULT = 4;

    function automatic logic [1:0] occ_count(input occ_t occ);
        case (occ)
            OCC_ONE: occ_count = 2'd1;
            OCC_TWO: occ_count = 2'd2;
            default: occ_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid
//   Two-entry head/tail buffer that absorbs the FIFO's read latency.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     capture    : write wr_data into the buffer tail this edge
//     pop        : head word consumed downstream this edge
//     wr_data    : word arriving from the FIFO
//     head       : oldest buffered word (registered)
//     valid      : buffer holds at least one word
//     occ        : occupancy state (EMPTY / ONE / TWO)
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  valid,
    output occ_t                  occ
);

    occ_t                  state;
    occ_t                  state_nx;
    logic [DATA_WIDTH-1:0] tail;

    always_comb begin
        // NOTE: default first so every path assigns state_nx; no latch is inferred.
        state_nx = state;
        case (state)
            OCC_EMPTY: if (capture)         state_nx = OCC_ONE;
            OCC_ONE:   if (capture && !pop) state_nx = OCC_TWO;
                       else if (!capture && pop) state_nx = OCC_EMPTY;
            OCC_TWO:   if (pop && !capture) state_nx = OCC_ONE;
            default:   state_nx = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OCC_EMPTY;
            // NOTE: data registers are reset too, because head drives m_data, which must read 0 out of reset.
            head  <= '0;
            tail  <= '0;
        end else begin
            // NOTE: non-blocking assignments so head/tail all update from pre-edge values.
            state <= state_nx;
            case (state)
                OCC_EMPTY: begin
                    if (capture) head <= wr_data;
                end
                OCC_ONE: begin
                    // With a pop the new word goes straight to the head; otherwise it queues behind it.
                    if (capture && pop)  head <= wr_data;
                    if (capture && !pop) tail <= wr_data;
                end
                OCC_TWO: begin
                    if (pop) head <= tail;
                    if (capture) tail <= wr_data;
                end
                default: ;
            endcase
        end
    end

    assign valid = (state != OCC_EMPTY);
    assign occ   = state;

    // Credit logic upstream must never deliver a third word.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(state == OCC_TWO && capture && !pop));

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Drains a synchronous FIFO (one-cycle read latency) and presents the words
//   as a valid/ready stream, buffering up to two words so none are lost under
//   backpressure.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     fifo_empty    : FIFO empty flag
//     fifo_rd_en    : FIFO read strobe (combinational)
//     fifo_rd_data  : FIFO read data, valid the cycle after an accepted read
//     m_valid/m_data/m_last/m_ready : output stream
//   Build option:
//     FIFO_RD_LAST_EN defined   -> beat counter drives m_last every PKT_LEN beats
//     FIFO_RD_LAST_EN undefined -> m_last tied to 0, PKT_LEN/CNT_WIDTH unused
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = PKT_LEN_DEFAULT,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    logic       inflight;
    logic       pop;
    occ_t       occ;
    logic [2:0] level;

    assign pop = m_valid & m_ready;

    // Words already committed to the buffer: held plus the one arriving next edge.
    // A read is allowed if, after this cycle's pop, that total stays below capacity.
    assign level      = {1'b0, occ_count(occ)} + {2'b00, inflight};
    assign fifo_rd_en = rst_n & ~fifo_empty & (level < (3'(OCC_MAX) + {2'b00, pop}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight <= 1'b0;
        else        inflight <= fifo_rd_en;
    end

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (inflight),
        .pop     (pop),
        .wr_data (fifo_rd_data),
        .head    (m_data),
        .valid   (m_valid),
        .occ     (occ)
    );

`ifdef FIFO_RD_LAST_EN
    logic [CNT_WIDTH-1:0] beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            if (beat_cnt == CNT_WIDTH'(PKT_LEN - 1)) beat_cnt <= '0;
            else                                     beat_cnt <= beat_cnt + 1'b1;
        end
    end

    assign m_last = m_valid & (beat_cnt == CNT_WIDTH'(PKT_LEN - 1));
`else
    logic [CNT_WIDTH-1:0] unused_pkt_len;
    assign unused_pkt_len = CNT_WIDTH'(PKT_LEN);
    assign m_last         = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
//   Bench for fifo_rd_stream driven by a behavioural 16-deep FIFO with
//   one-cycle read latency. A stream scoreboard checks order, hold stability,
//   m_last placement and the two-word holding bound every cycle; scenario
//   tasks add their own targeted checks.
module tb_fifo_rd_stream;

    localparam int DW    = 8;
    localparam int PKT   = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b0;

    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [DW-1:0] fq[$];     // FIFO contents
    logic [DW-1:0] exp_q[$];  // words expected on the stream, in order

    // scoreboard state
    int            beat, reads_total, pops_total, last_seen;
    int            empty_fall_cyc, first_valid_cyc;
    logic          prev_valid, prev_ready, prev_empty, first_pop_seen;
    logic [DW-1:0] prev_data, first_pop_data;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PKT),
        .CNT_WIDTH  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_ready      (m_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous FIFO: registered empty flag, registered read data.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            exp_q.delete();
            fifo_empty   <= 1'b1;
            fifo_rd_data <= '0;
        end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
            if (wr_en && fq.size() < DEPTH) begin
                fq.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Stream scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic          exp_last;
        logic [DW-1:0] exp_d;
        if (!rst_n) begin
            beat = 0; reads_total = 0; pops_total = 0; last_seen = 0;
            empty_fall_cyc = -1; first_valid_cyc = -1;
            prev_valid = 1'b0; prev_ready = 1'b0; prev_empty = 1'b1;
            prev_data = '0; first_pop_seen = 1'b0; first_pop_data = '0;
        end else begin
            vectors++;
            if (fifo_rd_en && fifo_empty) begin
                miscompares++;
                $display("FAIL rd_en_while_empty: rd_en=%0b empty=%0b (required rd_en=0)", fifo_rd_en, fifo_empty);
            end

            if (prev_valid && !prev_ready) begin
                vectors++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL hold_stable: valid=%0b data=%0d required valid=1 data=%0d", m_valid, m_data, prev_data);
                end
            end

`ifdef FIFO_RD_LAST_EN
            exp_last = m_valid && ((beat % PKT) == PKT - 1);
`else
            exp_last = 1'b0;
`endif
            vectors++;
            if (m_last !== exp_last) begin
                miscompares++;
                $display("FAIL m_last: beat=%0d got %0b required %0b", beat, m_last, exp_last);
            end

            if (m_valid && m_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_word: got %0d required no word", m_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (m_data !== exp_d) begin
                        miscompares++;
                        $display("FAIL order: beat=%0d got %0d required %0d", beat, m_data, exp_d);
                    end
                end
                if (!first_pop_seen) begin
                    first_pop_data = m_data;
                    first_pop_seen = 1'b1;
                end
                if (m_last) last_seen++;
                beat++;
                pops_total++;
            end

            if (fifo_rd_en) reads_total++;
            vectors++;
            if (reads_total - pops_total > 2) begin
                miscompares++;
                $display("FAIL held_words: got %0d required <= 2", reads_total - pops_total);
            end

            if (prev_empty && !fifo_empty && empty_fall_cyc < 0) empty_fall_cyc = cyc;
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
            prev_empty = fifo_empty;
        end
    end

    // ---------------- stimulus helpers (no checks) ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        wr_en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic write_words(input logic [DW-1:0] words[$]);
        foreach (words[i]) begin
            wr_en   = 1'b1;
            wr_data = words[i];
            tick(1);
        end
        wr_en = 1'b0;
    endtask

    // Wait until every written word has left the stream; returns 1 if budget expired.
    task automatic drain(input int budget, output logic timed_out);
        int n = 0;
        while ((fq.size() != 0 || exp_q.size() != 0 || m_valid) && n < budget) begin
            tick(1);
            n++;
        end
        tick(2);
        timed_out = (n >= budget);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        vectors++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 || fifo_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: valid=%0b data=%0d last=%0b rd_en=%0b required all 0", m_valid, m_data, m_last, fifo_rd_en);
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_streaming();
        logic [DW-1:0] w[$];
        logic          to;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) w.push_back(DW'(i));
        write_words(w);
        drain(60, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL stream_timeout: budget 60 cycles expired"); end
        vectors++;
        if (first_valid_cyc - empty_fall_cyc !== 2) begin
            miscompares++;
            $display("FAIL first_latency: got %0d cycles required 2", first_valid_cyc - empty_fall_cyc);
        end
        vectors++;
        if (pops_total !== 10) begin miscompares++; $display("FAIL stream_count: got %0d required 10", pops_total); end
        vectors++;
`ifdef FIFO_RD_LAST_EN
        if (last_seen !== 2) begin miscompares++; $display("FAIL stream_lasts: got %0d required 2", last_seen); end
`else
        if (last_seen !== 0) begin miscompares++; $display("FAIL stream_lasts: got %0d required 0", last_seen); end
`endif
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w[$];
        logic          to;
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) w.push_back(DW'(i));
        write_words(w);
        tick(6);
        vectors++;
        if (reads_total !== 2) begin miscompares++; $display("FAIL bp_reads: got %0d pulses required 2", reads_total); end
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 8'd0) begin
            miscompares++;
            $display("FAIL bp_head: valid=%0b data=%0d required valid=1 data=0", m_valid, m_data);
        end
        m_ready = 1'b1;
        drain(60, to);
        vectors++;
        if (to || pops_total !== 10) begin
            miscompares++;
            $display("FAIL bp_drain: got %0d words (timeout=%0b) required 10", pops_total, to);
        end
    endtask

    task automatic test_alternating();
        logic [DW-1:0] w[$] = '{8'd88, 8'd11, 8'd12, 8'd33};
        logic          to;
        do_reset();
        m_ready = 1'b0;
        fork
            write_words(w);
            for (int i = 0; i < 24; i++) begin
                m_ready = ~m_ready;
                tick(1);
            end
        join
        m_ready = 1'b1;
        drain(40, to);
        vectors++;
        if (to || pops_total !== 4) begin
            miscompares++;
            $display("FAIL alt_count: got %0d words (timeout=%0b) required 4", pops_total, to);
        end
    endtask

    task automatic test_idle();
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL idle: rd_en=%0b valid=%0b required 0/0", fifo_rd_en, m_valid);
            end
        end
        tick(1);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w[$] = '{8'd200, 8'd201, 8'd202};
        logic [DW-1:0] w2[$] = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        logic          to;
        int            exp_lasts;
        do_reset();
        m_ready = 1'b0;
        write_words(w);
        tick(3);
        vectors++;
        if (reads_total !== 2 || m_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_fill: reads=%0d valid=%0b required 2/1", reads_total, m_valid);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 || fifo_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%0b data=%0d last=%0b rd_en=%0b required all 0", m_valid, m_data, m_last, fifo_rd_en);
        end
        tick(2);
        rst_n = 1'b1;
        tick(1);
        m_ready = 1'b1;
        write_words(w2);
        drain(40, to);
        vectors++;
        if (to || first_pop_data !== 8'd5) begin
            miscompares++;
            $display("FAIL mid_first: got %0d (timeout=%0b) required 5", first_pop_data, to);
        end
`ifdef FIFO_RD_LAST_EN
        exp_lasts = 1;
`else
        exp_lasts = 0;
`endif
        vectors++;
        if (last_seen !== exp_lasts) begin
            miscompares++;
            $display("FAIL mid_lasts: got %0d required %0d", last_seen, exp_lasts);
        end
    endtask

    task automatic test_random();
        int   n_wr = 0;
        logic to;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (fq.size() < DEPTH - 2 && $urandom_range(0, 99) < 55) begin
                wr_en   = 1'b1;
                wr_data = DW'($urandom);
                n_wr++;
            end else begin
                wr_en = 1'b0;
            end
            m_ready = ($urandom_range(0, 99) < 60);
            tick(1);
        end
        wr_en   = 1'b0;
        m_ready = 1'b1;
        drain(100, to);
        vectors++;
        if (to || pops_total !== n_wr) begin
            miscompares++;
            $display("FAIL random_count: got %0d words (timeout=%0b) required %0d", pops_total, to, n_wr);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_alternating();
        test_idle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
